mem_stage: RTL and testbench

//  RV32I MEM stage: consumes the M-register outputs of the execute stage, drives a single-port data-memory bus

---
 rtl/mem_stage.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage.
// Drives a single-port data bus with a req/ready handshake, lane-aligns stores,
// extends loads, and registers every writeback field into the W pipeline register.
// Holds the front of the pipeline while an access is outstanding, and reports
// misaligned accesses and bus timeouts as exceptions on the retired op.
module mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead_M,
    input  logic        memWrite_M,
    input  logic        regWrite_M,
    input  logic [2:0]  resultScr_M,
    input  logic [2:0]  mode_M,
    input  logic [31:0] ALURuslt_M,
    input  logic [31:0] write_Data_M,
    input  logic [31:0] imm_extended_M,
    input  logic [31:0] pc4_M,
    input  logic [31:0] PC_target_mux_M,
    input  logic [4:0]  rd_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_M,
    output logic        regWrite_W,
    output logic [2:0]  resultScr_W,
    output logic [31:0] ReadData_W,
    output logic [31:0] ALURuslt_W,
    output logic [31:0] imm_extended_W,
    output logic [31:0] pc4_W,
    output logic [31:0] PC_target_W,
    output logic [4:0]  rd_W,
    output logic        mem_exc_W,
    output logic [1:0]  exc_code_W
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [1:0] EXC_NONE       = 2'b00;
    localparam logic [1:0] EXC_LD_MISALGN = 2'b01;
    localparam logic [1:0] EXC_ST_MISALGN = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT    = 2'b11;

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
        logic bad;
        case (mode[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte enables for a store at byte offset off; loads always read the full word.
    function automatic logic [3:0] store_be(input logic [2:0] mode, input logic [1:0] off);
        logic [3:0] be;
        case (mode[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    function automatic logic [31:0] store_data(input logic [2:0] mode, input logic [31:0] d);
        logic [31:0] w;
        case (mode[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it as funct3 requests.
    function automatic logic [31:0] load_extend(input logic [2:0] mode, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (mode)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic [0:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic        regWrite_q, regWrite_d;
    logic [2:0]  resultScr_q, resultScr_d;
    logic [31:0] ReadData_q, ReadData_d;
    logic [31:0] ALURuslt_q, ALURuslt_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pct_q, pct_d;
    logic [4:0]  rd_q, rd_d;
    logic        exc_q, exc_d;
    logic [1:0]  code_q, code_d;

    logic [1:0]  off;
    logic        is_mem;
    logic        misalign;
    logic        access_ok;
    logic        req;
    logic        stall;
    logic        complete;
    logic        timeout;
    logic [31:0] load_val;

    assign off       = ALURuslt_M[1:0];
    assign is_mem    = memRead_M | memWrite_M;
    assign misalign  = is_mem & is_misaligned(mode_M, off);
    assign access_ok = is_mem & ~misalign;
    assign load_val  = load_extend(mode_M, off, dmem_rdata);

    // Handshake FSM: issue in IDLE, hold the request in WAIT until ready or timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_ok) begin
                    req = 1'b1;
                    if (dmem_ready) begin
                        complete = 1'b1;
                    end else begin
                        // The issue cycle counts as the first stalled cycle of the budget.
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = TO_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    // Ready beats timeout when both land in the same cycle.
                    req      = 1'b1;
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == TO_W'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    req   = 1'b1;
                    stall = 1'b1;
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus side: reset gates req/stall so they drop the instant rst_n falls, even mid-WAIT.
    always_comb begin
        dmem_req   = req & rst_n;
        stall_M    = stall & rst_n;
        dmem_we    = req & rst_n & memWrite_M;
        dmem_addr  = {ALURuslt_M[31:2], 2'b00};
        dmem_be    = memWrite_M ? store_be(mode_M, off) : 4'b1111;
        dmem_wdata = store_data(mode_M, write_Data_M);
    end

    // Next W register contents: bubble while stalled, exception bubble on misalign/timeout.
    always_comb begin
        resultScr_d = resultScr_M;
        ALURuslt_d  = ALURuslt_M;
        imm_d       = imm_extended_M;
        pc4_d       = pc4_M;
        pct_d       = PC_target_mux_M;
        rd_d        = rd_M;
        ReadData_d  = (complete & memRead_M) ? load_val : 32'h0;
        regWrite_d  = regWrite_M;
        exc_d       = 1'b0;
        code_d      = EXC_NONE;
        if (stall) begin
            regWrite_d = 1'b0;
        end else if (misalign) begin
            regWrite_d = 1'b0;
            exc_d      = 1'b1;
            code_d     = memRead_M ? EXC_LD_MISALGN : EXC_ST_MISALGN;
        end else if (timeout) begin
            regWrite_d = 1'b0;
            exc_d      = 1'b1;
            code_d     = EXC_TIMEOUT;
        end
    end

    // FSM state and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // W pipeline register, loaded every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite_q  <= 1'b0;
            resultScr_q <= '0;
            ReadData_q  <= '0;
            ALURuslt_q  <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            pct_q       <= '0;
            rd_q        <= '0;
            exc_q       <= 1'b0;
            code_q      <= EXC_NONE;
        end else begin
            regWrite_q  <= regWrite_d;
            resultScr_q <= resultScr_d;
            ReadData_q  <= ReadData_d;
            ALURuslt_q  <= ALURuslt_d;
            imm_q       <= imm_d;
            pc4_q       <= pc4_d;
            pct_q       <= pct_d;
            rd_q        <= rd_d;
            exc_q       <= exc_d;
            code_q      <= code_d;
        end
    end

    assign regWrite_W     = regWrite_q;
    assign resultScr_W    = resultScr_q;
    assign ReadData_W     = ReadData_q;
    assign ALURuslt_W     = ALURuslt_q;
    assign imm_extended_W = imm_q;
    assign pc4_W          = pc4_q;
    assign PC_target_W    = pct_q;
    assign rd_W           = rd_q;
    assign mem_exc_W      = exc_q;
    assign exc_code_W     = code_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed bench for mem_stage with a word-level reference model.
module tb_mem_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead_M, memWrite_M, regWrite_M;
    logic [2:0]  resultScr_M, mode_M;
    logic [31:0] ALURuslt_M, write_Data_M, imm_extended_M, pc4_M, PC_target_mux_M;
    logic [4:0]  rd_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        stall_M;
    logic        regWrite_W;
    logic [2:0]  resultScr_W;
    logic [31:0] ReadData_W, ALURuslt_W, imm_extended_W, pc4_W, PC_target_W;
    logic [4:0]  rd_W;
    logic        mem_exc_W;
    logic [1:0]  exc_code_W;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .memRead_M(memRead_M), .memWrite_M(memWrite_M), .regWrite_M(regWrite_M),
        .resultScr_M(resultScr_M), .mode_M(mode_M), .ALURuslt_M(ALURuslt_M),
        .write_Data_M(write_Data_M), .imm_extended_M(imm_extended_M), .pc4_M(pc4_M),
        .PC_target_mux_M(PC_target_mux_M), .rd_M(rd_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stall_M(stall_M),
        .regWrite_W(regWrite_W), .resultScr_W(resultScr_W), .ReadData_W(ReadData_W),
        .ALURuslt_W(ALURuslt_W), .imm_extended_W(imm_extended_W), .pc4_W(pc4_W),
        .PC_target_W(PC_target_W), .rd_W(rd_W), .mem_exc_W(mem_exc_W), .exc_code_W(exc_code_W)
    );

    int total = 0;
    int bad   = 0;

    // Observations from the last run_op
    logic        o_req0, o_we0, o_held, o_req_last, o_hung;
    logic [31:0] o_addr0, o_wdata0;
    logic [3:0]  o_be0;
    int          o_stalls;
    // Pass-through values driven by the last run_op
    logic [2:0]  p_res;
    logic [31:0] p_imm, p_pc4, p_pct;
    logic [4:0]  p_rd;

    // Reference model, expressed as plain arithmetic on the funct3 rules
    function automatic logic [31:0] ref_load(input logic [2:0] mode, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint off = longint'(addr % 4);
        longint w   = longint'(rdata);
        longint v;
        case (mode)
            3'd0: begin v = (w >> (8 * off)) & 255;   if (v >= 128)   v -= 256;   end
            3'd1: begin v = (w >> (8 * off)) & 65535; if (v >= 32768) v -= 65536; end
            3'd4: v = (w >> (8 * off)) & 255;
            3'd5: v = (w >> (8 * off)) & 65535;
            default: v = w;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] ref_be(input logic is_store, input logic [2:0] mode,
                                          input logic [31:0] addr);
        int off = int'(addr % 4);
        if (!is_store) return 4'd15;
        if (mode == 3'd0) return 4'(1 << off);
        if (mode == 3'd1) return 4'(3 << off);
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] mode, input logic [31:0] d);
        if (mode == 3'd0) return (d & 32'hFF) * 32'h01010101;
        if (mode == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic ref_misalign(input logic [2:0] mode, input logic [31:0] addr);
        return ((mode % 4 == 1) && (addr % 2 != 0)) || ((mode % 4 == 2) && (addr % 4 != 0));
    endfunction

    // Present one M-stage op at posedge+1; ready arrives in cycle index `waits`.
    // Returns at posedge+1 right after the cycle in which stall_M was low.
    task automatic run_op(input logic rd, input logic wr, input logic regw, input logic [2:0] mode,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int waits);
        logic st;
        memRead_M = rd; memWrite_M = wr; regWrite_M = regw; mode_M = mode;
        ALURuslt_M = addr; write_Data_M = data;
        p_res = 3'($urandom); p_imm = $urandom; p_pc4 = $urandom; p_pct = $urandom; p_rd = 5'($urandom);
        resultScr_M = p_res; imm_extended_M = p_imm; pc4_M = p_pc4; PC_target_mux_M = p_pct; rd_M = p_rd;
        o_stalls = 0; o_held = 1'b1; o_hung = 1'b1;
        for (int c = 0; c < 64; c++) begin
            dmem_ready = (c == waits);
            dmem_rdata = (c == waits) ? rdata : $urandom;
            #4;
            if (c == 0) begin
                o_req0 = dmem_req; o_we0 = dmem_we; o_addr0 = dmem_addr;
                o_be0 = dmem_be; o_wdata0 = dmem_wdata;
            end else if (stall_M && (dmem_req !== 1'b1 || dmem_addr !== o_addr0 ||
                                     dmem_be !== o_be0 || dmem_wdata !== o_wdata0 ||
                                     dmem_we !== o_we0)) begin
                o_held = 1'b0;
            end
            o_req_last = dmem_req;
            st = stall_M;
            if (st) o_stalls++;
            @(posedge clk); #1;
            if (!st) begin o_hung = 1'b0; break; end
        end
        memRead_M = 1'b0; memWrite_M = 1'b0; regWrite_M = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        memRead_M = 1'b1; mode_M = 3'd2; ALURuslt_M = 32'h100; #1;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", dmem_req); end
        total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_M); end
        total++;
        if ({regWrite_W, resultScr_W, ReadData_W, ALURuslt_W, imm_extended_W, pc4_W, PC_target_W,
             rd_W, mem_exc_W, exc_code_W} !== '0) begin
            bad++; $display("FAIL reset_wreg got ALURuslt_W=%h ReadData_W=%h exc=%0b want all zero",
                            ALURuslt_W, ReadData_W, mem_exc_W);
        end
        memRead_M = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sw();
        run_op(1'b0, 1'b1, 1'b0, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        total++; if ({o_req0, o_we0} !== 2'b11) begin bad++; $display("FAIL sw_req_we got=%b want=11", {o_req0, o_we0}); end
        total++; if (o_be0 !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b want=1111", o_be0); end
        total++; if (o_wdata0 !== 32'hDEADBEEF || o_addr0 !== 32'h100) begin
            bad++; $display("FAIL sw_data got=%h@%h want=deadbeef@100", o_wdata0, o_addr0); end
        total++; if (o_stalls != 0) begin bad++; $display("FAIL sw_stall got=%0d want=0", o_stalls); end
        total++; if (mem_exc_W !== 1'b0) begin bad++; $display("FAIL sw_exc got=%0b want=0", mem_exc_W); end
    endtask

    task automatic test_load_wait();
        run_op(1'b1, 1'b0, 1'b1, 3'd0, 32'h103, 32'h0, 32'h80FFFF7F, 3);
        total++; if (o_stalls != 3) begin bad++; $display("FAIL lb_stalls got=%0d want=3", o_stalls); end
        total++; if (o_held !== 1'b1) begin bad++; $display("FAIL lb_held got=%0b want=1", o_held); end
        total++; if (ReadData_W !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", ReadData_W); end
        total++; if (regWrite_W !== 1'b1 || rd_W !== p_rd) begin
            bad++; $display("FAIL lb_wb got=%0b/%0d want=1/%0d", regWrite_W, rd_W, p_rd); end
        run_op(1'b1, 1'b0, 1'b1, 3'd4, 32'h103, 32'h0, 32'h80FFFF7F, 3);
        total++; if (ReadData_W !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h want=00000080", ReadData_W); end
    endtask

    task automatic test_sh();
        run_op(1'b0, 1'b1, 1'b0, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 1);
        total++; if (o_be0 !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b want=1100", o_be0); end
        total++; if (o_wdata0 !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%h want=abcdabcd", o_wdata0); end
        total++; if (o_addr0 !== 32'h200) begin bad++; $display("FAIL sh_addr got=%h want=00000200", o_addr0); end
    endtask

    task automatic test_misalign();
        run_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h105, 32'h0, 32'h0, 99);
        total++; if (o_req0 !== 1'b0 || o_stalls != 0) begin
            bad++; $display("FAIL lw_mis_req got req=%0b stalls=%0d want 0/0", o_req0, o_stalls); end
        total++; if ({regWrite_W, mem_exc_W, exc_code_W} !== 4'b0101) begin
            bad++; $display("FAIL lw_mis_w got=%b want=0101", {regWrite_W, mem_exc_W, exc_code_W}); end
        run_op(1'b0, 1'b1, 1'b1, 3'd1, 32'h101, 32'h55AA, 32'h0, 99);
        total++; if (o_req0 !== 1'b0 || {regWrite_W, mem_exc_W, exc_code_W} !== 4'b0110) begin
            bad++; $display("FAIL sh_mis got req=%0b w=%b want 0/0110", o_req0, {regWrite_W, mem_exc_W, exc_code_W}); end
    endtask

    task automatic test_timeout();
        logic [31:0] rdv;
        run_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h40, 32'h0, 32'h0, 99);
        total++; if (o_stalls != TIMEOUT) begin bad++; $display("FAIL to_stalls got=%0d want=%0d", o_stalls, TIMEOUT); end
        total++; if (o_req_last !== 1'b0) begin bad++; $display("FAIL to_req got=%0b want=0", o_req_last); end
        total++; if ({regWrite_W, mem_exc_W, exc_code_W} !== 4'b0111) begin
            bad++; $display("FAIL to_w got=%b want=0111", {regWrite_W, mem_exc_W, exc_code_W}); end
        rdv = $urandom;
        run_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h44, 32'h0, rdv, 0);
        total++; if (o_stalls != 0 || ReadData_W !== rdv || mem_exc_W !== 1'b0) begin
            bad++; $display("FAIL to_after got stalls=%0d data=%h want 0/%h", o_stalls, ReadData_W, rdv); end
    endtask

    task automatic test_passthrough();
        logic [31:0] a;
        a = $urandom;
        run_op(1'b0, 1'b0, 1'b1, 3'd2, a, 32'h0, 32'h0, 2);
        total++; if (o_req0 !== 1'b0 || o_stalls != 0) begin
            bad++; $display("FAIL pass_req got req=%0b stalls=%0d want 0/0", o_req0, o_stalls); end
        total++;
        if ({regWrite_W, ALURuslt_W, imm_extended_W, pc4_W, PC_target_W, rd_W, resultScr_W, mem_exc_W} !==
            {1'b1, a, p_imm, p_pc4, p_pct, p_rd, p_res, 1'b0}) begin
            bad++; $display("FAIL pass_w got alu=%h rd=%0d want alu=%h rd=%0d", ALURuslt_W, rd_W, a, p_rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rdv;
        memRead_M = 1'b1; regWrite_M = 1'b1; mode_M = 3'd2; ALURuslt_M = 32'h80; dmem_ready = 1'b0;
        repeat (3) begin #4; @(posedge clk); #1; end
        total++; if (stall_M !== 1'b1 || ALURuslt_W !== 32'h80) begin
            bad++; $display("FAIL rstw_pre got stall=%0b alu=%h want 1/00000080", stall_M, ALURuslt_W); end
        rst_n = 1'b0; #1;
        total++; if ({dmem_req, stall_M} !== 2'b00) begin
            bad++; $display("FAIL rstw_bus got=%b want=00", {dmem_req, stall_M}); end
        total++; if ({regWrite_W, ReadData_W, ALURuslt_W, pc4_W, rd_W, mem_exc_W, exc_code_W} !== '0) begin
            bad++; $display("FAIL rstw_w got alu=%h want 0", ALURuslt_W); end
        #3; rst_n = 1'b1;
        memRead_M = 1'b0; regWrite_M = 1'b0;
        @(posedge clk); #1;
        rdv = $urandom;
        run_op(1'b1, 1'b0, 1'b1, 3'd1, 32'h22, 32'h0, rdv, 2);
        total++; if (o_stalls != 2 || ReadData_W !== ref_load(3'd1, 32'h22, rdv)) begin
            bad++; $display("FAIL rstw_after got stalls=%0d data=%h want 2/%h", o_stalls, ReadData_W,
                            ref_load(3'd1, 32'h22, rdv)); end
    endtask

    task automatic test_random();
        logic        rd, wr, regw, mis;
        logic [2:0]  mode;
        logic [31:0] addr, data, rdv;
        int          kind, waits;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 2));
            rd = (kind == 0); wr = (kind == 1);
            case ($urandom_range(0, 4))
                0: mode = 3'd0; 1: mode = 3'd1; 2: mode = 3'd2; 3: mode = 3'd4; default: mode = 3'd5;
            endcase
            if (wr && mode[2]) mode = {1'b0, mode[1:0]};
            addr = $urandom; data = $urandom; rdv = $urandom;
            regw = wr ? 1'b0 : 1'($urandom);
            waits = int'($urandom_range(0, 6));
            mis = (rd || wr) && ref_misalign(mode, addr);
            run_op(rd, wr, regw, mode, addr, data, rdv, waits);
            if (mis) begin
                total++;
                if (o_req0 !== 1'b0 || o_stalls != 0 ||
                    {regWrite_W, mem_exc_W, exc_code_W} !== {2'b01, rd ? 2'b01 : 2'b10}) begin
                    bad++; $display("FAIL rnd_mis n=%0d got req=%0b st=%0d w=%b", n, o_req0, o_stalls,
                                    {regWrite_W, mem_exc_W, exc_code_W});
                end
            end else if ((rd || wr) && waits > TIMEOUT) begin
                total++;
                if (o_stalls != TIMEOUT || o_req_last !== 1'b0 || o_held !== 1'b1 ||
                    {regWrite_W, mem_exc_W, exc_code_W} !== 4'b0111) begin
                    bad++; $display("FAIL rnd_to n=%0d got st=%0d req=%0b w=%b want %0d/0/0111", n,
                                    o_stalls, o_req_last, {regWrite_W, mem_exc_W, exc_code_W}, TIMEOUT);
                end
            end else if (rd || wr) begin
                total++;
                if (o_stalls != waits || o_req0 !== 1'b1 || o_we0 !== wr || o_held !== 1'b1 ||
                    o_addr0 !== {addr[31:2], 2'b00} || o_be0 !== ref_be(wr, mode, addr)) begin
                    bad++; $display("FAIL rnd_bus n=%0d got st=%0d be=%b addr=%h want st=%0d be=%b", n,
                                    o_stalls, o_be0, o_addr0, waits, ref_be(wr, mode, addr));
                end
                total++;
                if ((wr && o_wdata0 !== ref_wdata(mode, data)) || (rd && ReadData_W !== ref_load(mode, addr, rdv))) begin
                    bad++; $display("FAIL rnd_data n=%0d got wd=%h rd=%h want wd=%h rd=%h", n, o_wdata0,
                                    ReadData_W, ref_wdata(mode, data), ref_load(mode, addr, rdv));
                end
                total++;
                if ({regWrite_W, mem_exc_W, ALURuslt_W, rd_W, pc4_W} !== {regw, 1'b0, addr, p_rd, p_pc4}) begin
                    bad++; $display("FAIL rnd_wb n=%0d got rw=%0b exc=%0b alu=%h want rw=%0b alu=%h", n,
                                    regWrite_W, mem_exc_W, ALURuslt_W, regw, addr);
                end
            end else begin
                total++;
                if (o_req0 !== 1'b0 || o_stalls != 0 ||
                    {regWrite_W, mem_exc_W, ALURuslt_W, imm_extended_W, PC_target_W, resultScr_W} !==
                    {regw, 1'b0, addr, p_imm, p_pct, p_res}) begin
                    bad++; $display("FAIL rnd_alu n=%0d got rw=%0b alu=%h want rw=%0b alu=%h", n,
                                    regWrite_W, ALURuslt_W, regw, addr);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        memRead_M = 1'b0; memWrite_M = 1'b0; regWrite_M = 1'b0;
        resultScr_M = '0; mode_M = '0; ALURuslt_M = '0; write_Data_M = '0;
        imm_extended_M = '0; pc4_M = '0; PC_target_mux_M = '0; rd_M = '0;
        dmem_rdata = '0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sw();
        test_load_wait();
        test_sh();
        test_misalign();
        test_timeout();
        test_passthrough();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
